// File: rtl/eth_tx_arbiter_pkg.sv
// Shared types and constants for the Ethernet transmit arbiter.
// States, inter-frame gap timing, and the counter sizing rule.
package eth_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_SEND  = 2'd2,
    ARB_IFG   = 2'd3
  } arb_states;

  localparam int ETH_IFG_BYTES      = 12;
  localparam int RMII_CLKS_PER_BYTE = 4;

  // Sized so the larger of the two limits is reachable and the counter never wraps.
  function automatic int counter_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/eth_tx_arbiter_if.sv
// Source-side and serializer-side signals of the TX arbiter.
// "master" is the arbiter's view; "slave" is the environment's view.
interface eth_tx_arbiter_if #(
  parameter int NUM_SRC = 4
) ();
  localparam int IDX_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]   src_valid;
  logic [8*NUM_SRC-1:0] src_data;
  logic [NUM_SRC-1:0]   src_last;
  logic [NUM_SRC-1:0]   src_ready;
  logic                 tx_valid;
  logic [7:0]           tx_data;
  logic                 tx_last;
  logic                 tx_ready;
  logic                 tx_abort;
  logic [IDX_W-1:0]     grant_idx;
  logic                 busy;

  modport master (
    input  src_valid, src_data, src_last, tx_ready,
    output src_ready, tx_valid, tx_data, tx_last, tx_abort, grant_idx, busy
  );

  modport slave (
    output src_valid, src_data, src_last, tx_ready,
    input  src_ready, tx_valid, tx_data, tx_last, tx_abort, grant_idx, busy
  );
endinterface

// File: rtl/eth_tx_arbiter_rr_picker.sv
// Round-robin requester selection: first set request bit at or after ptr, wrapping.
module eth_tx_arbiter_rr_picker #(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   grant,
  output logic               any_req
);

  // Scan from the farthest offset back to ptr so the nearest requester wins.
  always_comb begin
    logic [IDX_W:0]   sum_s;
    logic [IDX_W-1:0] idx_s;
    grant   = {IDX_W{1'b0}};
    any_req = 1'b0;
    sum_s   = {(IDX_W + 1){1'b0}};
    idx_s   = {IDX_W{1'b0}};
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      sum_s = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (sum_s >= (IDX_W + 1)'(NUM_SRC)) begin
        sum_s = sum_s - (IDX_W + 1)'(NUM_SRC);
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[IDX_W-1:0];
      if (req[idx_s]) begin
        grant   = idx_s;
        any_req = 1'b1;
      end else begin
        any_req = any_req;
      end
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Round-robin, frame-at-a-time arbiter for the shared RMII transmit byte path,
// with inter-frame gap enforcement and mid-frame stall abort.
module eth_tx_arbiter
  import eth_tx_arbiter_pkg::*;
#(
  parameter int NUM_SRC       = 4,
  parameter int IFG_CYCLES    = ETH_IFG_BYTES * RMII_CLKS_PER_BYTE,
  parameter int STALL_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             resetn,
  eth_tx_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int CNT_W = counter_width(IFG_CYCLES, STALL_TIMEOUT);

  localparam logic [1:0] ST_IDLE  = ARB_IDLE;
  localparam logic [1:0] ST_GRANT = ARB_GRANT;
  localparam logic [1:0] ST_SEND  = ARB_SEND;
  localparam logic [1:0] ST_IFG   = ARB_IFG;

  localparam logic [CNT_W-1:0] IFG_LAST   = CNT_W'(IFG_CYCLES - 1);
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_TIMEOUT - 1);

  logic [1:0]         state_r;
  logic [IDX_W-1:0]   grant_r;
  logic [IDX_W-1:0]   ptr_r;
  logic [CNT_W-1:0]   ifg_cnt_r;
  logic [CNT_W-1:0]   stall_cnt_r;
  logic               abort_r;
  logic [IDX_W-1:0]   pick_s;
  logic [IDX_W-1:0]   ptr_next_s;
  logic               any_req_s;
  logic               sending_s;
  logic               g_valid_s;
  logic               g_last_s;
  logic [7:0]         g_data_s;
  logic               xfer_s;
  logic [NUM_SRC-1:0] ready_s;

  eth_tx_arbiter_rr_picker #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req     (bus.src_valid),
    .ptr     (ptr_r),
    .grant   (pick_s),
    .any_req (any_req_s)
  );

  // Forward path from the granted source; forced quiet outside SEND.
  always_comb begin
    g_valid_s = bus.src_valid[grant_r];
    g_last_s  = bus.src_last[grant_r];
    g_data_s  = bus.src_data[{grant_r, 3'b000} +: 8];
    sending_s = (state_r == ST_SEND);
    xfer_s    = sending_s & g_valid_s & bus.tx_ready;
    ready_s   = {NUM_SRC{1'b0}};
    if (sending_s) begin
      ready_s[grant_r] = bus.tx_ready;
    end else begin
      ready_s = {NUM_SRC{1'b0}};
    end
    if (grant_r == IDX_W'(NUM_SRC - 1)) begin
      ptr_next_s = {IDX_W{1'b0}};
    end else begin
      ptr_next_s = grant_r + IDX_W'(1);
    end
  end

  assign bus.tx_valid  = sending_s & g_valid_s;
  assign bus.tx_data   = sending_s ? g_data_s : 8'h00;
  assign bus.tx_last   = sending_s & g_valid_s & g_last_s;
  assign bus.src_ready = ready_s;
  assign bus.tx_abort  = abort_r;
  assign bus.grant_idx = grant_r;
  assign bus.busy      = (state_r != ST_IDLE);

  // Arbitration FSM with gap and stall counters; tx_abort is a one-clock pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= ST_IDLE;
      grant_r     <= {IDX_W{1'b0}};
      ptr_r       <= {IDX_W{1'b0}};
      ifg_cnt_r   <= {CNT_W{1'b0}};
      stall_cnt_r <= {CNT_W{1'b0}};
      abort_r     <= 1'b0;
    end else begin
      abort_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            grant_r <= pick_s;
            state_r <= ST_GRANT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          ptr_r       <= ptr_next_s;
          stall_cnt_r <= {CNT_W{1'b0}};
          state_r     <= ST_SEND;
        end
        ST_SEND: begin
          if (xfer_s) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            if (g_last_s) begin
              ifg_cnt_r <= {CNT_W{1'b0}};
              state_r   <= ST_IFG;
            end else begin
              state_r <= ST_SEND;
            end
          end else if (!g_valid_s) begin
            // Backpressure from the serializer is not a stall; only a silent source is.
            if (stall_cnt_r == STALL_LAST) begin
              abort_r     <= 1'b1;
              stall_cnt_r <= {CNT_W{1'b0}};
              ifg_cnt_r   <= {CNT_W{1'b0}};
              state_r     <= ST_IFG;
            end else begin
              stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end
          end else begin
            state_r <= ST_SEND;
          end
        end
        ST_IFG: begin
          if (ifg_cnt_r == IFG_LAST) begin
            ifg_cnt_r <= {CNT_W{1'b0}};
            state_r   <= ST_IDLE;
          end else begin
            ifg_cnt_r <= ifg_cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Scoreboard bench for eth_tx_arbiter: per-source frame drivers, an expected-byte
// queue filled in predicted grant order, and a negedge monitor that checks it.
module tb_eth_tx_arbiter;

  localparam int NS = 4;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         gap;
  } item_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [1:0] src;
  } exp_t;

  logic clk;
  logic resetn;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   xfer_total = 0;

  item_t src_q[NS][$];
  exp_t  exp_q[$];
  int    abort_q[$];

  eth_tx_arbiter_if #(.NUM_SRC(NS)) bus ();

  eth_tx_arbiter #(
    .NUM_SRC       (NS),
    .IFG_CYCLES    (48),
    .STALL_TIMEOUT (64)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input int src, input int n, input int seed,
                            input bit has_last, input int gap_at, input int gap_len);
    item_t it;
    exp_t  e;
    for (int i = 0; i < n; i++) begin
      it.data = 8'(seed + i * 7);
      it.last = has_last && (i == n - 1);
      it.gap  = (i == gap_at) ? gap_len : 0;
      src_q[src].push_back(it);
      e.data = it.data;
      e.last = it.last;
      e.src  = 2'(src);
      exp_q.push_back(e);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    chk(name, 64'({bus.tx_valid, bus.tx_data, bus.tx_last, bus.tx_abort,
                   bus.src_ready, bus.grant_idx, bus.busy}), 64'(0));
  endtask

  task automatic wait_idle(input bit toggle, input string name);
    bit done;
    bit empty;
    done = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      step();
      if (toggle) tx_ready_set(cyc % 4 == 0);
      empty = 1'b1;
      for (int i = 0; i < NS; i++) if (src_q[i].size() != 0) empty = 1'b0;
      if (empty && exp_q.size() == 0 && abort_q.size() == 0 && !bus.busy) done = 1'b1;
    end
    chk({name, "_done"}, 64'(done), 64'(1));
  endtask

  task automatic tx_ready_set(input bit v);
    bus.tx_ready = v;
  endtask

  // Source drivers: present queued bytes, honour per-byte valid gaps, advance on handshake.
  initial begin : driver
    logic [NS-1:0]   fire;
    logic [NS-1:0]   v;
    logic [NS-1:0]   l;
    logic [8*NS-1:0] d;
    int              hold[NS];
    bit              loaded[NS];
    v = '0; l = '0; d = '0;
    for (int i = 0; i < NS; i++) begin hold[i] = 0; loaded[i] = 1'b0; end
    bus.src_valid = '0;
    bus.src_last  = '0;
    bus.src_data  = '0;
    forever begin
      @(negedge clk);
      fire = bus.src_valid & bus.src_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) begin
        if (fire[i] && src_q[i].size() > 0) begin
          src_q[i].delete(0);
          loaded[i] = 1'b0;
        end
        if (src_q[i].size() == 0) begin
          loaded[i] = 1'b0;
          v[i] = 1'b0;
          l[i] = 1'b0;
        end else begin
          if (!loaded[i]) begin
            hold[i]   = src_q[i][0].gap;
            loaded[i] = 1'b1;
          end
          if (hold[i] == 0) begin
            v[i]          = 1'b1;
            l[i]          = src_q[i][0].last;
            d[8*i +: 8]   = src_q[i][0].data;
          end else begin
            hold[i]--;
            v[i] = 1'b0;
            l[i] = 1'b0;
          end
        end
      end
      bus.src_valid = v;
      bus.src_last  = l;
      bus.src_data  = d;
    end
  end

  // Monitor: scoreboard pops, grant latency, ready isolation, abort and gap length.
  initial begin : monitor
    exp_t e;
    int   a;
    int   rise_cyc;
    int   end_exp;
    bit   busy_prev;
    bit   lat_pending;
    bit   end_pending;
    busy_prev = 1'b0; lat_pending = 1'b0; end_pending = 1'b0;
    rise_cyc = 0; end_exp = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        busy_prev = 1'b0; lat_pending = 1'b0; end_pending = 1'b0;
      end else begin
        if (!busy_prev && bus.busy) begin rise_cyc = cyc; lat_pending = 1'b1; end
        if (bus.tx_valid && lat_pending) begin
          chk("latency", 64'(cyc), 64'(rise_cyc + 1));
          lat_pending = 1'b0;
        end
        if (bus.tx_valid) begin
          chk("ready_excl", 64'(bus.src_ready & ~(NS'(1) << bus.grant_idx)), 64'(0));
          chk("ready_mirror", 64'(bus.src_ready[bus.grant_idx]), 64'(bus.tx_ready));
        end
        if (bus.tx_valid && bus.tx_ready) begin
          xfer_total++;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL byte_unexpected: got src %0d data 0x%0h, expected no byte",
                     bus.grant_idx, bus.tx_data);
          end else begin
            e = exp_q.pop_front();
            chk("byte", 64'({bus.grant_idx, bus.tx_last, bus.tx_data}),
                64'({e.src, e.last, e.data}));
            if (bus.tx_last) begin end_pending = 1'b1; end_exp = cyc + 49; end
          end
        end
        if (bus.tx_abort) begin
          if (abort_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL abort_unexpected: got abort from src %0d, expected none", bus.grant_idx);
          end else begin
            a = abort_q.pop_front();
            chk("abort_src", 64'(bus.grant_idx), 64'(a));
          end
          end_pending = 1'b1;
          end_exp = cyc + 48;
        end
        if (busy_prev && !bus.busy && end_pending) begin
          chk("ifg_len", 64'(cyc), 64'(end_exp));
          end_pending = 1'b0;
        end
        busy_prev = bus.busy;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base;
    bit hit;
    resetn = 1'b0;
    bus.tx_ready = 1'b1;
    repeat (3) step();
    check_reset_outputs("rst_init");
    resetn = 1'b1;
    step();

    // Single 60-byte frame from source 3; pointer wraps back to 0 afterwards.
    send_frame(3, 60, 8'h10, 1'b1, -1, 0);
    wait_idle(1'b0, "t1_single");

    // Three simultaneous requesters from pointer 0; source 2 sends a 1-byte frame.
    send_frame(0, 8, 8'h40, 1'b1, -1, 0);
    send_frame(1, 5, 8'h80, 1'b1, -1, 0);
    send_frame(2, 1, 8'hC0, 1'b1, -1, 0);
    wait_idle(1'b0, "t2_rr012");
    send_frame(3, 4, 8'h20, 1'b1, -1, 0);
    send_frame(0, 3, 8'h60, 1'b1, -1, 0);
    wait_idle(1'b0, "t2_rr30");

    // Serializer accepts only one clock in four.
    send_frame(1, 20, 8'h55, 1'b1, -1, 0);
    wait_idle(1'b1, "t3_backpressure");
    bus.tx_ready = 1'b1;

    // Source 2 goes silent after byte 10 and gets aborted; source 0 follows.
    abort_q.push_back(2);
    send_frame(2, 10, 8'h33, 1'b0, -1, 0);
    send_frame(0, 6, 8'h99, 1'b1, -1, 0);
    wait_idle(1'b0, "t4_abort");

    // A 63-clock stall before byte 11 is tolerated.
    send_frame(1, 15, 8'h11, 1'b1, 10, 63);
    wait_idle(1'b0, "t5_stall63");

    // Reset after the fifth byte of a source-2 frame.
    base = xfer_total;
    send_frame(2, 12, 8'hA0, 1'b1, -1, 0);
    hit = 1'b0;
    for (int n = 0; n < 500 && !hit; n++) begin
      step();
      if (xfer_total >= base + 5) hit = 1'b1;
    end
    chk("t6_reach_byte5", 64'(xfer_total - base), 64'(5));
    resetn = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    src_q[2].delete();
    exp_q.delete();
    repeat (2) step();
    resetn = 1'b1;
    step();
    send_frame(1, 4, 8'hD0, 1'b1, -1, 0);
    send_frame(3, 4, 8'hE0, 1'b1, -1, 0);
    wait_idle(1'b0, "t6_after_reset");

    repeat (5) step();
    chk("drain", 64'(exp_q.size() + abort_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
